fir_decim_buffer: RTL and testbench

//   Downstream stage of the 13-tap symmetric FIR; consumes its signed 8-bit dout stream.

---
 rtl/fir_decim_buffer_pkg.sv | 5 +
 rtl/fir_decim_buffer_if.sv | 13 +
 rtl/fir_decim_buffer_sync_fifo.sv | 57 +++++
 rtl/fir_decim_buffer.sv | 77 +++++++
 tb/tb_fir_decim_buffer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fir_decim_buffer_pkg.sv
// Shared sample type for the FIR decimation buffer slice.
package fir_decim_buffer_pkg;
    localparam int SAMPLE_W = 8;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/fir_decim_buffer_if.sv
// Sample-in / decimated-out stream bundle; master is the buffer itself.
interface fir_decim_buffer_if;
    import fir_decim_buffer_pkg::*;

    sample_t din;
    logic    in_valid;
    sample_t m_data;
    logic    m_valid;
    logic    m_ready;

    modport master (input din, in_valid, m_ready, output m_data, m_valid);
    modport slave  (output din, in_valid, m_ready, input m_data, m_valid);
endinterface

// File: rtl/fir_decim_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head; head holds the last popped word when empty.
module fir_decim_buffer_sync_fifo #(
    parameter int DATA_W = fir_decim_buffer_pkg::SAMPLE_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic              do_push;
    logic              do_pop;

    assign empty      = (level == '0);
    assign full       = (level == LVL_W'(DEPTH));
    assign do_pop     = pop & ~empty;
    assign do_push    = push & (~full | do_pop);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr_nxt;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            // New word becomes head directly when nothing older remains behind it.
            if (do_push && (empty || (do_pop && level == LVL_W'(1))))
                head <= push_data;
            else if (do_pop && level > LVL_W'(1))
                head <= mem[rd_ptr_nxt];
        end
    end
endmodule

// File: rtl/fir_decim_buffer.sv
// Drops FIR warm-up samples, boxcar-averages blocks of DECIM samples and queues results.
module fir_decim_buffer #(
    parameter int DECIM      = 4,
    parameter int WARMUP     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    fir_decim_buffer_if.master            bus,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    input  logic                          clr_ovf
);
    import fir_decim_buffer_pkg::*;

    localparam int LOG2_DECIM = $clog2(DECIM);
    localparam int ACC_W      = SAMPLE_W + LOG2_DECIM;
    localparam int WARM_W     = $clog2(WARMUP + 1);

    logic [WARM_W-1:0]       warm_cnt;
    logic [LOG2_DECIM-1:0]   phase;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] din_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    warm_done;
    logic                    accept;
    logic                    last;
    logic                    push;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    drop;
    sample_t                 result;

    assign warm_done = (warm_cnt == WARM_W'(WARMUP));
    assign accept    = bus.in_valid & warm_done;
    assign last      = (phase == LOG2_DECIM'(DECIM - 1));
    assign push      = accept & last;
    assign din_ext   = {{LOG2_DECIM{bus.din[SAMPLE_W-1]}}, bus.din};
    assign sum       = acc + din_ext;
    // Dropping the low bits of a signed sum is a flooring divide; the mean of
    // DECIM 8-bit samples always lands back in 8-bit range.
    assign result    = sum[ACC_W-1:LOG2_DECIM];
    assign drop      = push & fifo_full & ~(bus.m_ready & ~fifo_empty);
    assign bus.m_valid = ~fifo_empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            warm_cnt <= '0;
            phase    <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            if (bus.in_valid && !warm_done) warm_cnt <= warm_cnt + WARM_W'(1);
            if (accept) begin
                phase <= phase + LOG2_DECIM'(1);
                acc   <= (phase == '0) ? din_ext : sum;
            end
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    fir_decim_buffer_sync_fifo #(
        .DATA_W (SAMPLE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_sync_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .push_data (result),
        .pop       (bus.m_ready),
        .head      (bus.m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );
endmodule

// File: tb/tb_fir_decim_buffer.sv
// Scenario bench for fir_decim_buffer: scoreboard queue filled at stimulus time, checked at output.
module tb_fir_decim_buffer;
    import fir_decim_buffer_pkg::*;

    localparam int DECIM  = 4;
    localparam int WARMUP = 17;
    localparam int DEPTH  = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             clr_ovf = 1'b0;
    logic [LVL_W-1:0] level;
    logic             ovf;

    fir_decim_buffer_if bus ();

    fir_decim_buffer #(.DECIM(DECIM), .WARMUP(WARMUP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus), .level(level), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int      total = 0;
    int      bad = 0;
    sample_t exp_q[$];
    int      mdl_warm, mdl_cnt, mdl_sum;
    logic    mdl_ovf;

    function automatic int floor_div(input int s);
        int q;
        q = s / DECIM;
        if ((s % DECIM != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: sums samples as plain integers and queues the floored mean.
    always @(posedge clk) begin
        bit pop_now, push_now;
        int res;
        if (n_rst) begin
            pop_now  = bus.m_ready && (exp_q.size() != 0);
            push_now = 1'b0;
            res      = 0;
            if (bus.in_valid) begin
                if (mdl_warm < WARMUP) mdl_warm++;
                else begin
                    mdl_sum += int'(bus.din);
                    mdl_cnt++;
                    if (mdl_cnt == DECIM) begin
                        push_now = 1'b1;
                        res      = floor_div(mdl_sum);
                        mdl_sum  = 0;
                        mdl_cnt  = 0;
                    end
                end
            end
            if (pop_now) void'(exp_q.pop_front());
            if (push_now && exp_q.size() == DEPTH) mdl_ovf = 1'b1;
            else begin
                if (push_now) exp_q.push_back(8'(res));
                if (clr_ovf) mdl_ovf = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        mdl_warm = 0; mdl_cnt = 0; mdl_sum = 0; mdl_ovf = 1'b0;
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        bus.din = '0; bus.in_valid = 1'b0; bus.m_ready = 1'b0; clr_ovf = 1'b0;
        model_clear();
        step();
        step();
        n_rst = 1'b1;
    endtask

    task automatic feed(input int v, input logic vld);
        bus.din = 8'(v);
        bus.in_valid = vld;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic warm();
        for (int i = 0; i < WARMUP; i++) feed(0, 1'b1);
    endtask

    task automatic block(input int a, input int b, input int c, input int d);
        feed(a, 1'b1); feed(b, 1'b1); feed(c, 1'b1); feed(d, 1'b1);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", bus.m_valid); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        total++; if (bus.m_data !== 8'd0) begin bad++; $display("FAIL reset_m_data got=%0d want=0", bus.m_data); end
    endtask

    task automatic test_warmup_latency();
        bit exp_v;
        apply_reset();
        bus.din = 8'd10; bus.in_valid = 1'b1; bus.m_ready = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            exp_v = (cyc >= 21) && ((cyc - 21) % 4 == 0);
            total++; if (bus.m_valid !== exp_v) begin bad++; $display("FAIL warmup_valid cyc=%0d got=%b want=%b", cyc, bus.m_valid, exp_v); end
            total++; if (level !== LVL_W'(exp_q.size())) begin bad++; $display("FAIL warmup_level cyc=%0d got=%0d want=%0d", cyc, level, exp_q.size()); end
            if (exp_v) begin
                total++; if (bus.m_data !== 8'sd10) begin bad++; $display("FAIL warmup_data cyc=%0d got=%0d want=10", cyc, bus.m_data); end
            end
        end
        bus.in_valid = 1'b0; bus.m_ready = 1'b0;
    endtask

    task automatic drain(input string name, input int want[$]);
        bus.m_ready = 1'b1;
        foreach (want[i]) begin
            total++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(want[i]) || exp_q.size() == 0 || bus.m_data !== exp_q[0])
                begin bad++; $display("FAIL %s_entry%0d got=%0d valid=%b want=%0d", name, i, bus.m_data, bus.m_valid, want[i]); end
            step();
        end
        bus.m_ready = 1'b0;
        total++; if (bus.m_valid !== 1'b0 || level !== '0) begin bad++; $display("FAIL %s_empty got valid=%b level=%0d want 0/0", name, bus.m_valid, level); end
        total++; if (bus.m_data !== 8'(want[want.size()-1])) begin bad++; $display("FAIL %s_hold got=%0d want=%0d", name, bus.m_data, want[want.size()-1]); end
    endtask

    task automatic test_floor_and_gaps();
        apply_reset();
        warm();
        block(-1, -1, -1, -2);
        total++; if (bus.m_valid !== 1'b1 || bus.m_data !== -8'sd2) begin bad++; $display("FAIL floor_neg got=%0d valid=%b want=-2", bus.m_data, bus.m_valid); end
        feed(5, 1'b1); feed(99, 1'b0); feed(6, 1'b1); feed(-50, 1'b0); feed(-50, 1'b0); feed(7, 1'b1); feed(8, 1'b1);
        block(0, 0, 0, -3);
        total++; if (level !== LVL_W'(3)) begin bad++; $display("FAIL floor_level got=%0d want=3", level); end
        drain("floor", '{-2, 6, -1});
    endtask

    task automatic test_extremes();
        apply_reset();
        warm();
        block(-128, -128, -128, -128);
        block(127, 127, 127, 127);
        drain("extreme", '{-128, 127});
    endtask

    task automatic test_overflow();
        int want[$];
        apply_reset();
        warm();
        for (int k = 1; k <= 9; k++) begin
            block(k * 25 - 130, k * 25 - 130, k * 25 - 130, k * 25 - 129);
            if (k <= 8) want.push_back(k * 25 - 130);
            if (k == 8) begin
                total++; if (level !== LVL_W'(8) || ovf !== 1'b0) begin bad++; $display("FAIL ovf_fill got level=%0d ovf=%b want 8/0", level, ovf); end
            end
        end
        total++; if (level !== LVL_W'(8) || ovf !== 1'b1 || mdl_ovf !== 1'b1) begin bad++; $display("FAIL ovf_drop got level=%0d ovf=%b want 8/1", level, ovf); end
        drain("ovf", want);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf); end
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", ovf); end
    endtask

    task automatic test_full_push_pop();
        int want[$];
        apply_reset();
        warm();
        for (int k = 1; k <= 8; k++) block(k * 10, k * 10, k * 10, k * 10);
        feed(90, 1'b1); feed(90, 1'b1); feed(90, 1'b1);
        bus.m_ready = 1'b1;
        feed(91, 1'b1);
        bus.m_ready = 1'b0;
        total++; if (level !== LVL_W'(8) || ovf !== 1'b0) begin bad++; $display("FAIL fullpp_level got level=%0d ovf=%b want 8/0", level, ovf); end
        total++; if (bus.m_data !== 8'sd20) begin bad++; $display("FAIL fullpp_head got=%0d want=20", bus.m_data); end
        feed(1, 1'b1); feed(1, 1'b1); feed(1, 1'b1);
        clr_ovf = 1'b1;
        feed(1, 1'b1);
        clr_ovf = 1'b0;
        total++; if (ovf !== 1'b1 || level !== LVL_W'(8)) begin bad++; $display("FAIL fullpp_set_prio got ovf=%b level=%0d want 1/8", ovf, level); end
        for (int k = 2; k <= 9; k++) want.push_back(k * 10);
        drain("fullpp", want);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        warm();
        block(7, 7, 7, 7); block(7, 7, 7, 7); block(7, 7, 7, 7);
        feed(7, 1'b1); feed(7, 1'b1);
        total++; if (level !== LVL_W'(3)) begin bad++; $display("FAIL rstmid_pre got=%0d want=3", level); end
        #2;
        n_rst = 1'b0;
        model_clear();
        #1;
        total++; if (bus.m_valid !== 1'b0 || level !== '0) begin bad++; $display("FAIL rstmid_async got valid=%b level=%0d want 0/0", bus.m_valid, level); end
        step();
        n_rst = 1'b1;
        bus.din = 8'sd7; bus.in_valid = 1'b1;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            step();
            total++; if (bus.m_valid !== (cyc == 21)) begin bad++; $display("FAIL rstmid_rewarm cyc=%0d got=%b want=%b", cyc, bus.m_valid, cyc == 21); end
        end
        bus.in_valid = 1'b0;
        total++; if (bus.m_data !== 8'sd7) begin bad++; $display("FAIL rstmid_data got=%0d want=7", bus.m_data); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_warmup_latency();
        test_floor_and_gaps();
        test_extremes();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
